// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational lookup on the fetch PC, trained at the clock edge from the EX-stage outcome.
module branch_target_buffer #(
    parameter int ENTRIES    = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic                  branch_taken_ex,
    input  logic [ADDR_WIDTH-1:0] target_addr_ex,
    output logic [ADDR_WIDTH-1:0] predicted_target,
    output logic                  hit
);

    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;

    logic                  valid_mem  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_mem    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_mem [ENTRIES];
    logic [1:0]            ctr_mem    [ENTRIES];

    logic [INDEX_BITS-1:0] index_if;
    logic [INDEX_BITS-1:0] index_ex;
    logic [TAG_BITS-1:0]   tag_if;
    logic [TAG_BITS-1:0]   tag_ex;
    logic                  match_ex;
    logic                  unused_pc_bits;

    assign index_if = pc_if[INDEX_BITS+1:2];
    assign index_ex = pc_ex[INDEX_BITS+1:2];
    assign tag_if   = pc_if[ADDR_WIDTH-1:INDEX_BITS+2];
    assign tag_ex   = pc_ex[ADDR_WIDTH-1:INDEX_BITS+2];

    // Instructions are word aligned, so the byte offset never selects an entry.
    assign unused_pc_bits = ^{pc_if[1:0], pc_ex[1:0]};

    assign hit = valid_mem[index_if] && (tag_mem[index_if] == tag_if) && ctr_mem[index_if][1];
    assign predicted_target = hit ? target_mem[index_if] : '0;

    assign match_ex = valid_mem[index_ex] && (tag_mem[index_ex] == tag_ex);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: every array is cleared here because an asynchronous reset must wipe all
            // predictions at once; this keeps the storage in flops rather than a RAM macro.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_mem[i]  <= 1'b0;
                tag_mem[i]    <= '0;
                target_mem[i] <= '0;
                ctr_mem[i]    <= 2'b00;
            end
        end else if (branch_taken_ex) begin
            // NOTE: non-blocking writes keep the lookup seeing pre-edge contents this cycle.
            target_mem[index_ex] <= target_addr_ex;
            if (match_ex) begin
                if (ctr_mem[index_ex] != 2'b11) begin
                    ctr_mem[index_ex] <= ctr_mem[index_ex] + 2'd1;
                end
            end else begin
                valid_mem[index_ex] <= 1'b1;
                tag_mem[index_ex]   <= tag_ex;
                ctr_mem[index_ex]   <= 2'b10;
            end
        end else if (match_ex && (ctr_mem[index_ex] != 2'b00)) begin
            ctr_mem[index_ex] <= ctr_mem[index_ex] - 2'd1;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: a per-PC behavioural model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_branch_target_buffer;

    localparam int ENTRIES = 64;

    logic        clk;
    logic        reset;
    logic [63:0] pc_if;
    logic [63:0] pc_ex;
    logic        branch_taken_ex;
    logic [63:0] target_addr_ex;
    logic [63:0] predicted_target;
    logic        hit;

    int total = 0;
    int bad   = 0;

    branch_target_buffer #(.ENTRIES(ENTRIES), .ADDR_WIDTH(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_if            (pc_if),
        .pc_ex            (pc_ex),
        .branch_taken_ex  (branch_taken_ex),
        .target_addr_ex   (target_addr_ex),
        .predicted_target (predicted_target),
        .hit              (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each slot remembers which PC (by its upper bits) owns it and an integer counter.
    typedef struct {
        bit          valid;
        logic [63:0] owner;
        logic [63:0] target;
        int          ctr;
    } slot_t;

    slot_t model [ENTRIES];

    function automatic int slot_of(input logic [63:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [63:0] owner_of(input logic [63:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit model_hit(input logic [63:0] pc);
        slot_t s;
        s = model[slot_of(pc)];
        return s.valid && (s.owner == owner_of(pc)) && (s.ctr >= 2);
    endfunction

    function automatic logic [63:0] model_target(input logic [63:0] pc);
        return model_hit(pc) ? model[slot_of(pc)].target : 64'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                model[i].valid  <= 1'b0;
                model[i].owner  <= '0;
                model[i].target <= '0;
                model[i].ctr    <= 0;
            end
        end else begin
            int    e;
            bit    owns;
            e    = slot_of(pc_ex);
            owns = model[e].valid && (model[e].owner == owner_of(pc_ex));
            if (branch_taken_ex) begin
                model[e].target <= target_addr_ex;
                if (owns) begin
                    model[e].ctr <= (model[e].ctr + 1 > 3) ? 3 : model[e].ctr + 1;
                end else begin
                    model[e].valid <= 1'b1;
                    model[e].owner <= owner_of(pc_ex);
                    model[e].ctr   <= 2;
                end
            end else if (owns) begin
                model[e].ctr <= (model[e].ctr - 1 < 0) ? 0 : model[e].ctr - 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_hit", {63'd0, hit}, {63'd0, model_hit(pc_if)});
        check("model_target", predicted_target, model_target(pc_if));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pe, input logic tk, input logic [63:0] tg);
        pc_ex           = pe;
        branch_taken_ex = tk;
        target_addr_ex  = tg;
    endtask

    task automatic idle();
        drive(64'h0, 1'b0, 64'h0);
    endtask

    task automatic look(input string name, input logic [63:0] pc,
                        input logic exp_hit, input logic [63:0] exp_tgt);
        pc_if = pc;
        #1;
        check({name, "_hit"}, {63'd0, hit}, {63'd0, exp_hit});
        check({name, "_target"}, predicted_target, exp_tgt);
    endtask

    task automatic update(input logic [63:0] pe, input logic tk, input logic [63:0] tg);
        drive(pe, tk, tg);
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b0;
        pc_if = 64'hdead_beef_cafe_f00c;
        idle();
        #1;
        check("reset_hit", {63'd0, hit}, 64'd0);
        check("reset_target", predicted_target, 64'd0);
        #11;
        reset = 1'b1;
        look("post_reset", 64'h1000, 1'b0, 64'h0);
        tick();

        // Allocate, then lookup the cycle after the edge.
        drive(64'h1000, 1'b1, 64'h2000);
        look("alloc_same_cycle", 64'h1000, 1'b0, 64'h0);
        tick();
        idle();
        look("alloc", 64'h1000, 1'b1, 64'h2000);
        look("alias_miss", 64'h1100, 1'b0, 64'h0);

        // Alias steals the shared slot.
        update(64'h1100, 1'b1, 64'h3000);
        look("alias_owner", 64'h1100, 1'b1, 64'h3000);
        look("alias_evicted", 64'h1000, 1'b0, 64'h0);

        // Hysteresis and saturation.
        for (int i = 0; i < 3; i++) update(64'h1000, 1'b1, 64'h2000);
        look("sat_hi", 64'h1000, 1'b1, 64'h2000);
        update(64'h1000, 1'b0, 64'h0);
        look("nt1", 64'h1000, 1'b1, 64'h2000);
        update(64'h1000, 1'b0, 64'h0);
        look("nt2", 64'h1000, 1'b0, 64'h0);
        update(64'h1000, 1'b0, 64'h0);
        update(64'h1000, 1'b0, 64'h0);
        look("sat_lo", 64'h1000, 1'b0, 64'h0);
        update(64'h1000, 1'b1, 64'h2000);
        look("from_zero_t1", 64'h1000, 1'b0, 64'h0);
        update(64'h1000, 1'b1, 64'h2000);
        look("from_zero_t2", 64'h1000, 1'b1, 64'h2000);

        // Same-cycle update and lookup (ctr=10 now): no bypass.
        drive(64'h1000, 1'b0, 64'h0);
        look("nb_nt_same", 64'h1000, 1'b1, 64'h2000);
        tick();
        idle();
        look("nb_nt_after", 64'h1000, 1'b0, 64'h0);
        update(64'h1000, 1'b1, 64'h2000);
        drive(64'h1000, 1'b1, 64'h4000);
        look("nb_t_same", 64'h1000, 1'b1, 64'h2000);
        tick();
        idle();
        look("nb_t_after", 64'h1000, 1'b1, 64'h4000);

        // Populate more slots, then pulse reset between edges.
        update(64'h2004, 1'b1, 64'h5000);
        update(64'h3008, 1'b1, 64'h6000);
        look("pop_a", 64'h2004, 1'b1, 64'h5000);
        look("pop_b", 64'h3008, 1'b1, 64'h6000);
        drive(64'h2004, 1'b1, 64'h7000);
        @(negedge clk);
        #1;
        reset = 1'b0;
        look("rst_mid_a", 64'h1000, 1'b0, 64'h0);
        look("rst_mid_b", 64'h2004, 1'b0, 64'h0);
        look("rst_mid_c", 64'h3008, 1'b0, 64'h0);
        reset = 1'b1;
        idle();
        tick();
        look("rst_post_a", 64'h1000, 1'b0, 64'h0);
        look("rst_post_b", 64'h2004, 1'b0, 64'h0);
        look("rst_post_c", 64'h3008, 1'b0, 64'h0);

        // First edge after release accepts an update.
        update(64'h1000, 1'b1, 64'h8000);
        look("after_release", 64'h1000, 1'b1, 64'h8000);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
